voice_match_scorer: RTL
=======================

# voice_match_scorer

Streaming template scorer for the voice-recognition path. Compares a frame of `WORDS` sample words from sample RAM against a stored dictionary template, `LANES` byte lanes per word. Counts every lane whose absolute difference is within `THRESH`, then presents the frame score through a valid/ready handshake. It sits between the RAM/dictionary read sequencer and the best-match selector.

## Interface
Parameters:
- `LANES`, default 4: byte lanes per word (≥1).
- `WORDS`, default 256: words per frame (≥1).
- `THRESH`, default 15: inclusive per-lane match threshold (0..255).
- Derived `SW` = `$clog2(LANES*WORDS+1)`: score width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a frame; honoured only in IDLE.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `ram_data`  in  8*LANES  sample word; lane i = bits [8i+7:8i].
- `dir_data`  in  8*LANES  template word, same lane packing.
- `score`  out  SW  match count for the completed frame.
- `score_valid`  out  1  score available.
- `score_ready`  in  1  consumer accepts the score.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `in_ready`=0. On `start`: clear the accumulator and beat counter, then go to RUN.
- RUN: `in_ready`=1. Each accepted beat enters the pipeline and increments the beat counter. Bubbles on `in_valid` are allowed and change nothing.
  - When beat `WORDS` is accepted, go to DRAIN and drop `in_ready` on the next cycle.
- Pipeline stage 1 registers a per-lane match bit, `|ram - dir| <= THRESH`.
  - Difference is computed exactly in 9 bits, unsigned by default.
  - No modular wrap: 0x00 vs 0xFF is a difference of 255.
- Pipeline stage 2 adds the popcount of the match bits (0..LANES) into the `SW`-bit accumulator. The accumulator never overflows by construction.
- DRAIN: waits until the final beat has passed stage 2, then goes to DONE.
- DONE: `score_valid`=1 and `score` is held stable. On `score_ready`, go to IDLE the next cycle; `score_valid` deasserts.
- `start` in any state other than IDLE is ignored.
- `in_valid` outside RUN is ignored; the data is never counted.

## Timing
- Reset values: `in_ready`=0, `score_valid`=0, `score`=0, `busy`=0. State is IDLE and all pipeline registers and counters are 0.
- `start` sampled high in IDLE at edge t:
  - RUN from t.
  - `in_ready` and `busy` high after t.
- The final beat is accepted at edge k. `score_valid` rises after edge k+2 (2-cycle latency), with `score` valid in the same cycle.
- `score_valid` and `score_ready` both high at edge d:
  - IDLE after d.
  - `score_valid`=0 after d.
  - `score` retains its value until the next frame clears it at `start`.
- `start` in the same cycle as the handshake is ignored (state is still DONE). The earliest accepted `start` is one cycle after `score_valid` falls.
- Minimum frame time is `WORDS`+3 cycles from `start` to `score_valid`.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial frame is discarded. The next frame after reset scores correctly.

## Configuration
- `VOICE_SIGNED_SAMPLES_EN`:
  - Defined: each lane byte is a signed two's-complement sample. The difference is computed as a sign-extended 9-bit signed subtraction, and its absolute value (0..255) is compared with `THRESH`.
  - Undefined: lanes are unsigned, as described under Operation.
  - Timing and interface are identical in both builds.

## Test plan
All scenarios use `LANES`=4, `WORDS`=4, `THRESH`=15.
- Identical words: `start`, then 4 beats with ram = dir = 0x5A5A5A5A -> `score`=16, `score_valid` 2 cycles after the 4th beat.
- Threshold edge: ram=0x10101010 with dir=0x1F1F1F1F ×4 -> 16. Same ram with dir=0x20202020 ×4 -> 0. Mixed dir=0x1F20_1F20 ×4 -> 8.
- Wrap: ram=0x00000000, dir=0xFFFFFFFF ×4 -> 0 unsigned. With `VOICE_SIGNED_SAMPLES_EN` -> 16 (0 vs −1).
- Bubbles and backpressure: `in_valid` toggled 1,0,0,1,… and `score_ready` held low 5 cycles after `score_valid`:
  - score held stable.
  - `in_ready`=0.
  - a `start` pulse in DONE is ignored.
  - IDLE one cycle after `score_ready`.
- Reset mid-frame: assert `rst` after 2 accepted beats -> all outputs 0 and `busy`=0. A following full frame of matches -> 16.
- Out-of-frame data: `in_valid`=1 with matching data in IDLE for 3 cycles, then `start` plus 4 mismatching beats -> 0.

Source files
------------

// File: rtl/voice_match_scorer_if.sv
// ---------------------------------------------------------------------------
// voice_match_scorer_if
//   Bundles the handshake and data signals between the RAM/dictionary read
//   sequencer (master) and voice_match_scorer (slave).
//   master drives : start, in_valid, ram_data, dir_data, score_ready
//   slave  drives : in_ready, score, score_valid, busy
//   ram_data / dir_data pack lane i into bits [8i+7:8i].
// ---------------------------------------------------------------------------
interface voice_match_scorer_if #(
  parameter int LANES = 4,
  parameter int WORDS = 256
);
  localparam int SW = $clog2(LANES * WORDS + 1);

  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   ram_data;
  logic [8*LANES-1:0]   dir_data;
  logic [SW-1:0]        score;
  logic                 score_valid;
  logic                 score_ready;
  logic                 busy;

  modport master (
    output start, in_valid, ram_data, dir_data, score_ready,
    input  in_ready, score, score_valid, busy
  );

  modport slave (
    input  start, in_valid, ram_data, dir_data, score_ready,
    output in_ready, score, score_valid, busy
  );
endinterface

// File: rtl/voice_match_scorer.sv
// ---------------------------------------------------------------------------
// voice_match_scorer
//   Streams a frame of WORDS sample words against a dictionary template and
//   counts byte lanes whose absolute difference is <= THRESH. The frame score
//   is presented through a valid/ready handshake.
//
//   Ports:
//     clk  - system clock
//     rst  - asynchronous active-high reset
//     bus  - voice_match_scorer_if.slave (start, in_valid/in_ready,
//            ram_data, dir_data, score/score_valid/score_ready, busy)
//
//   Build option:
//     VOICE_SIGNED_SAMPLES_EN - when defined, lane bytes are signed
//     two's-complement samples; otherwise unsigned.
//
//   Pipeline: stage 1 registers per-lane match bits, stage 2 adds their
//   popcount into the accumulator. score_valid rises two edges after the
//   final beat is accepted.
// ---------------------------------------------------------------------------
module voice_match_scorer #(
  parameter int LANES  = 4,
  parameter int WORDS  = 256,
  parameter int THRESH = 15
) (
  input logic                 clk,
  input logic                 rst,
  voice_match_scorer_if.slave bus
);

  localparam int SW = $clog2(LANES * WORDS + 1);
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW = $clog2(LANES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LANES-1:0] match_q, match_d;
  logic             s1_valid_q, s1_valid_d;
  logic [SW-1:0]    acc_q, acc_d;

  logic             accept;
  logic [LANES-1:0] lane_match;
  logic [PW-1:0]    popcnt;

  assign accept = (state_q == S_RUN) && bus.in_valid;

  // Both builds subtract in 9 bits; only the extension bit differs. The
  // 9-bit result covers -255..255 exactly, so no modular wrap can occur.
  always_comb begin
    logic [8:0] a9, b9, diff9, abs9;
    lane_match = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
`ifdef VOICE_SIGNED_SAMPLES_EN
      a9 = {bus.ram_data[8*i+7], bus.ram_data[8*i +: 8]};
      b9 = {bus.dir_data[8*i+7], bus.dir_data[8*i +: 8]};
`else
      a9 = {1'b0, bus.ram_data[8*i +: 8]};
      b9 = {1'b0, bus.dir_data[8*i +: 8]};
`endif
      diff9 = a9 - b9;
      abs9  = diff9[8] ? (~diff9 + 9'd1) : diff9;
      lane_match[i] = (abs9 <= 9'(THRESH));
    end
  end

  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      popcnt = popcnt + PW'(match_q[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    match_d    = match_q;
    s1_valid_d = 1'b0;
    acc_d      = acc_q;

    if (accept) begin
      match_d    = lane_match;
      s1_valid_d = 1'b1;
    end

    if (s1_valid_q) begin
      acc_d = acc_q + SW'(popcnt);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WORDS - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      // The final beat sits in stage 1 on the first DRAIN cycle; once it has
      // been accumulated the stage-1 valid is low and the score is complete.
      S_DRAIN: begin
        if (!s1_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.score_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      match_q    <= '0;
      s1_valid_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      s1_valid_q <= s1_valid_d;
      acc_q      <= acc_d;
    end
  end

  assign bus.in_ready    = (state_q == S_RUN);
  assign bus.score_valid = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.score       = acc_q;

endmodule
